// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared types and defaults for the RAM access controller
package mem_access_ctrl_pkg;

  localparam int BITS_DEF    = 32;
  localparam int RAMSIZE_DEF = 512;
  localparam int STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_CAP = 3'd2,
    ST_WR     = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    MDR_SRC_WDATA = 1'b0,
    MDR_SRC_RAM   = 1'b1
  } mdr_src_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response handshake between control unit and controller
interface mem_access_ctrl_if import mem_access_ctrl_pkg::*; #(
  parameter int BITS = BITS_DEF
) ();

  logic            req_valid;
  logic            req_write;
  logic [BITS-1:0] req_addr;
  logic [BITS-1:0] req_wdata;
  logic            req_ready;
  logic            rsp_valid;
  logic            rsp_err;
  logic [BITS-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_mdr_reg.sv
// rtl/mem_access_ctrl_mdr_reg.sv - memory data register with store-data / RAM-data source select
module mem_access_ctrl_mdr_reg import mem_access_ctrl_pkg::*; #(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  mdr_src_t        src,
  input  logic [BITS-1:0] wdata,
  input  logic [BITS-1:0] ram_data,
  output logic [BITS-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= (src == MDR_SRC_RAM) ? ram_data : wdata;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request RAM initiator owning MAR/MDR and sequencing read/write strobes
module mem_access_ctrl import mem_access_ctrl_pkg::*; #(
  parameter int BITS    = BITS_DEF,
  parameter int RAMSIZE = RAMSIZE_DEF,
  parameter int ADDR    = $clog2(RAMSIZE)
) (
  input  logic               clk,
  input  logic               clr,
  mem_access_ctrl_if.slave   bus,
  output logic [ADDR-1:0]    mar,
  output logic [ADDR-1:0]    ram_address,
  output logic [BITS-1:0]    ram_dataIn,
  output logic               ram_read,
  output logic               ram_write,
  input  logic [BITS-1:0]    ram_dataOut
);

  state_t          state;
  logic [BITS-1:0] mdr;
  logic            mdr_load;
  mdr_src_t        mdr_src;
  logic            addr_bad;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;

  assign addr_bad = |bus.req_addr[BITS-1:ADDR];

  // MDR takes store data at acceptance even if the address is later rejected
  always_comb begin
    mdr_load = 1'b0;
    mdr_src  = MDR_SRC_WDATA;
    if (state == ST_IDLE && bus.req_valid && bus.req_write) begin
      mdr_load = 1'b1;
    end else if (state == ST_RD_CAP) begin
      mdr_load = 1'b1;
      mdr_src  = MDR_SRC_RAM;
    end
  end

  mem_access_ctrl_mdr_reg #(.BITS(BITS)) u_mdr (
    .clk      (clk),
    .clr      (clr),
    .load     (mdr_load),
    .src      (mdr_src),
    .wdata    (bus.req_wdata),
    .ram_data (ram_dataOut),
    .q        (mdr)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_IDLE;
      mar         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            mar         <= bus.req_addr[ADDR-1:0];
            req_ready_q <= 1'b0;
            if (addr_bad) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else if (bus.req_write) begin
              ram_write <= 1'b1;
              state     <= ST_WR;
            end else begin
              ram_read <= 1'b1;
              state    <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          ram_read <= 1'b0;
          state    <= ST_RD_CAP;
        end
        // RAM output is valid here, one cycle after the read strobe
        ST_RD_CAP: begin
          rsp_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_WR: begin
          ram_write   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          ram_read    <= 1'b0;
          ram_write   <= 1'b0;
        end
      endcase
    end
  end

  assign ram_address   = mar;
  assign ram_dataIn    = mdr;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = mdr;

  a_strobe_excl: assert property (@(posedge clk) !(ram_read && ram_write));
  a_read_pulse:  assert property (@(posedge clk) ram_read |=> !ram_read);
  a_write_pulse: assert property (@(posedge clk) ram_write |=> !ram_write);
  a_rsp_pulse:   assert property (@(posedge clk) bus.rsp_valid |=> !bus.rsp_valid);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int BITS    = 32;
  localparam int RAMSIZE = 512;
  localparam int ADDR    = 9;

  logic              clk = 1'b0;
  logic              clr;
  logic              ram_init;
  logic [ADDR-1:0]   mar;
  logic [ADDR-1:0]   ram_address;
  logic [BITS-1:0]   ram_dataIn;
  logic              ram_read;
  logic              ram_write;
  logic [BITS-1:0]   ram_dataOut;

  logic [BITS-1:0]   ram     [0:RAMSIZE-1];
  logic [BITS-1:0]   ref_mem [0:RAMSIZE-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.BITS(BITS)) bus ();

  mem_access_ctrl #(.BITS(BITS), .RAMSIZE(RAMSIZE), .ADDR(ADDR)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .mar         (mar),
    .ram_address (ram_address),
    .ram_dataIn  (ram_dataIn),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_dataOut (ram_dataOut)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0888_0055;
    return (i * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  // single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < RAMSIZE; i++) ram[i] <= init_word(i);
    end else begin
      if (ram_write) ram[ram_address] <= ram_dataIn;
      if (ram_read) ram_dataOut <= ram[ram_address];
    end
  end

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output bit accepted, output int lat, output int rsp_cnt,
                        output logic err, output logic [31:0] rdata, output logic [8:0] mar_seen,
                        output int rd_cnt, output int rd_at, output int wr_cnt, output int wr_at,
                        output bit overlap, output logic [8:0] strobe_addr,
                        output logic [31:0] strobe_data);
    int k;
    accepted = 0; lat = -1; rsp_cnt = 0; err = 1'bx; rdata = 'x; mar_seen = 'x;
    rd_cnt = 0; rd_at = -1; wr_cnt = 0; wr_at = -1; overlap = 0;
    strobe_addr = 'x; strobe_data = 'x;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    accepted = (bus.req_ready === 1'b1);
    if (!accepted) begin
      bus.req_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (ram_read && ram_write) overlap = 1;
      if (ram_read) begin
        rd_cnt++; rd_at = c; strobe_addr = ram_address;
      end
      if (ram_write) begin
        wr_cnt++; wr_at = c; strobe_addr = ram_address; strobe_data = ram_dataIn;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (lat < 0) begin
          lat = c; err = bus.rsp_err; rdata = bus.rsp_rdata; mar_seen = mar;
        end
      end
    end
  endtask

  bit          t_acc, t_ovl;
  int          t_lat, t_rsp, t_rdc, t_rda, t_wrc, t_wra;
  logic        t_err;
  logic [31:0] t_rdata, t_sdata;
  logic [8:0]  t_mar, t_saddr;

  task automatic test_reset();
    clr = 1'b1; ram_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
    checks++; if ({ram_read, ram_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {ram_read, ram_write}); end
    checks++; if (mar !== 9'd0) begin errors++; $display("FAIL reset_mar got %h exp 000", mar); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    clr = 1'b0; ram_init = 1'b0;
  endtask

  task automatic test_store_load();
    access(1'b1, 32'd85, 32'h0000_F7F7, t_acc, t_lat, t_rsp, t_err, t_rdata, t_mar,
           t_rdc, t_rda, t_wrc, t_wra, t_ovl, t_saddr, t_sdata);
    ref_mem[85] = 32'h0000_F7F7;
    checks++; if (t_acc !== 1'b1) begin errors++; $display("FAIL st_accept got %b exp 1", t_acc); end
    checks++; if (t_lat !== 2) begin errors++; $display("FAIL st_latency got %0d exp 2", t_lat); end
    checks++; if (t_wrc !== 1 || t_wra !== 1) begin errors++; $display("FAIL st_write_strobe got cnt %0d at %0d exp cnt 1 at 1", t_wrc, t_wra); end
    checks++; if (t_saddr !== 9'd85) begin errors++; $display("FAIL st_ram_address got %0d exp 85", t_saddr); end
    checks++; if (t_sdata !== 32'h0000_F7F7) begin errors++; $display("FAIL st_ram_dataIn got %h exp 0000f7f7", t_sdata); end
    checks++; if (t_rdc !== 0) begin errors++; $display("FAIL st_no_read got %0d exp 0", t_rdc); end
    access(1'b0, 32'd85, 32'h0, t_acc, t_lat, t_rsp, t_err, t_rdata, t_mar,
           t_rdc, t_rda, t_wrc, t_wra, t_ovl, t_saddr, t_sdata);
    checks++; if (t_lat !== 3) begin errors++; $display("FAIL ld85_latency got %0d exp 3", t_lat); end
    checks++; if (t_rdata !== ref_mem[85]) begin errors++; $display("FAIL ld85_rdata got %h exp %h", t_rdata, ref_mem[85]); end
  endtask

  task automatic test_latency();
    access(1'b0, 32'd4, 32'h0, t_acc, t_lat, t_rsp, t_err, t_rdata, t_mar,
           t_rdc, t_rda, t_wrc, t_wra, t_ovl, t_saddr, t_sdata);
    checks++; if (t_rdc !== 1 || t_rda !== 1) begin errors++; $display("FAIL lat_read_strobe got cnt %0d at %0d exp cnt 1 at 1", t_rdc, t_rda); end
    checks++; if (t_lat !== 3 || t_rsp !== 1) begin errors++; $display("FAIL lat_rsp got at %0d cnt %0d exp at 3 cnt 1", t_lat, t_rsp); end
    checks++; if (t_rdata !== 32'h0888_0055) begin errors++; $display("FAIL lat_rdata got %h exp 08880055", t_rdata); end
    checks++; if (t_ovl !== 1'b0 || t_wrc !== 0) begin errors++; $display("FAIL lat_strobes got ovl %b wr %0d exp 0 0", t_ovl, t_wrc); end
  endtask

  task automatic test_range_error();
    access(1'b0, 32'h200, 32'h0, t_acc, t_lat, t_rsp, t_err, t_rdata, t_mar,
           t_rdc, t_rda, t_wrc, t_wra, t_ovl, t_saddr, t_sdata);
    checks++; if (t_lat !== 1 || t_rsp !== 1) begin errors++; $display("FAIL rerr_rsp got at %0d cnt %0d exp at 1 cnt 1", t_lat, t_rsp); end
    checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL rerr_flag got %b exp 1", t_err); end
    checks++; if (t_rdc !== 0 || t_wrc !== 0) begin errors++; $display("FAIL rerr_strobes got rd %0d wr %0d exp 0 0", t_rdc, t_wrc); end
    checks++; if (t_mar !== 9'h000) begin errors++; $display("FAIL rerr_mar got %h exp 000", t_mar); end
  endtask

  task automatic test_boundary();
    access(1'b1, 32'd511, 32'hDEAD_BEEF, t_acc, t_lat, t_rsp, t_err, t_rdata, t_mar,
           t_rdc, t_rda, t_wrc, t_wra, t_ovl, t_saddr, t_sdata);
    ref_mem[511] = 32'hDEAD_BEEF;
    checks++; if (t_err !== 1'b0 || t_saddr !== 9'd511) begin errors++; $display("FAIL bnd_store got err %b addr %0d exp 0 511", t_err, t_saddr); end
    access(1'b0, 32'd511, 32'h0, t_acc, t_lat, t_rsp, t_err, t_rdata, t_mar,
           t_rdc, t_rda, t_wrc, t_wra, t_ovl, t_saddr, t_sdata);
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL bnd_load_err got %b exp 0", t_err); end
    checks++; if (t_rdata !== ref_mem[511]) begin errors++; $display("FAIL bnd_load_rdata got %h exp %h", t_rdata, ref_mem[511]); end
  endtask

  task automatic test_back_to_back();
    bit          op_w [8];
    logic [31:0] op_a [8];
    logic [31:0] op_d [8];
    int          acc  [8];
    logic [31:0] exp_q [$];
    bit          expw_q [$];
    logic [31:0] e;
    bit          ew, took;
    int          idx = 0, nrsp = 0, cyc = 0;
    for (int i = 0; i < 8; i++) begin
      op_w[i] = (i % 2 == 0);
      op_a[i] = 32'd10 + 32'((i / 2) % 2);
      op_d[i] = $urandom;
      acc[i]  = -1;
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = op_w[0]; bus.req_addr = op_a[0]; bus.req_wdata = op_d[0];
    while (nrsp < 8 && cyc < 80) begin
      took = 0;
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_rsp got rsp at cycle %0d exp none", cyc);
        end else begin
          e = exp_q.pop_front(); ew = expw_q.pop_front();
          if (!ew && bus.rsp_rdata !== e) begin
            errors++; $display("FAIL b2b_rdata got %h exp %h", bus.rsp_rdata, e);
          end
        end
        nrsp++;
      end
      if (bus.req_ready === 1'b1 && idx < 8) begin
        acc[idx] = cyc;
        if (op_w[idx]) ref_mem[op_a[idx]] = op_d[idx];
        exp_q.push_back(ref_mem[op_a[idx]]);
        expw_q.push_back(op_w[idx]);
        idx++; took = 1;
      end
      @(negedge clk); cyc++;
      if (took) begin
        if (idx < 8) begin
          bus.req_write = op_w[idx]; bus.req_addr = op_a[idx]; bus.req_wdata = op_d[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    checks++; if (idx !== 8 || nrsp !== 8) begin errors++; $display("FAIL b2b_counts got acc %0d rsp %0d exp 8 8", idx, nrsp); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (acc[i+1] - acc[i] !== (op_w[i] ? 3 : 4)) begin
        errors++; $display("FAIL b2b_interval op %0d got %0d exp %0d", i, acc[i+1] - acc[i], op_w[i] ? 3 : 4);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'd20;
    for (int k = 0; k < 10 && bus.req_ready !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rml_req_ready got %b exp 1", bus.req_ready); end
    checks++; if (mar !== 9'd0) begin errors++; $display("FAIL rml_mar got %h exp 000", mar); end
    checks++; if (ram_read !== 1'b0) begin errors++; $display("FAIL rml_ram_read got %b exp 0", ram_read); end
    for (int k = 0; k < 5; k++) begin
      if (bus.rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rml_no_rsp got %0d pulses exp 0", seen); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    bit          w, bad;
    for (int n = 0; n < 40; n++) begin
      w = $urandom_range(0, 1);
      d = $urandom;
      if ($urandom_range(0, 5) == 0) a = (32'($urandom_range(1, 255)) << 9) | 32'($urandom_range(0, 511));
      else a = 32'($urandom_range(0, 511));
      bad = (a >= 32'(RAMSIZE));
      access(w, a, d, t_acc, t_lat, t_rsp, t_err, t_rdata, t_mar,
             t_rdc, t_rda, t_wrc, t_wra, t_ovl, t_saddr, t_sdata);
      checks++;
      if (t_lat !== (bad ? 1 : (w ? 2 : 3)) || t_rsp !== 1) begin
        errors++; $display("FAIL rnd_latency op %0d got %0d cnt %0d exp %0d", n, t_lat, t_rsp, bad ? 1 : (w ? 2 : 3));
      end
      checks++;
      if (t_err !== bad || t_mar !== a[8:0]) begin
        errors++; $display("FAIL rnd_err_mar op %0d got %b %h exp %b %h", n, t_err, t_mar, bad, a[8:0]);
      end
      checks++;
      if (t_ovl || t_rdc !== ((!bad && !w) ? 1 : 0) || t_wrc !== ((!bad && w) ? 1 : 0)) begin
        errors++; $display("FAIL rnd_strobes op %0d got rd %0d wr %0d ovl %b", n, t_rdc, t_wrc, t_ovl);
      end
      if (!bad && w) ref_mem[a[8:0]] = d;
      if (!bad && !w) begin
        checks++;
        if (t_rdata !== ref_mem[a[8:0]]) begin
          errors++; $display("FAIL rnd_rdata op %0d got %h exp %h", n, t_rdata, ref_mem[a[8:0]]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < RAMSIZE; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_store_load();
    test_latency();
    test_range_error();
    test_boundary();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the single-port word RAM. It accepts one load/store request at a time from the control unit and holds the address in an internal MAR and the data in an internal MDR. It sequences the RAM read/write strobes so they are never asserted together, captures read data after the RAM's one-cycle registered read latency, then returns a one-cycle response. It sits between the control unit/bus and the RAM, and owns the MAR/MDR pair.

Parameters:
BITS, 32, data and request-address width
RAMSIZE, 512, number of RAM words
ADDR, $clog2(RAMSIZE), RAM address width; MAR width

Ports:
clk  input  1  system clock; all state changes on its rising edge
clr  input  1  synchronous active-high reset
req_valid  input  1  control unit presents a request
req_write  input  1  1 = store, 0 = load; sampled with req_valid
req_addr  input  BITS  word address
req_wdata  input  BITS  store data
req_ready  output  1  controller can accept a request this cycle
rsp_valid  output  1  one-cycle pulse: access complete
rsp_err  output  1  valid with rsp_valid: address out of range, no access made
rsp_rdata  output  BITS  MDR contents; valid with rsp_valid on a load
mar  output  ADDR  current MAR value
ram_address  output  ADDR  to RAM address; always equals mar
ram_dataIn  output  BITS  to RAM dataIn; always equals MDR
ram_read  output  1  to RAM read strobe
ram_write  output  1  to RAM write strobe
ram_dataOut  input  BITS  from RAM dataOut

Behaviour:
- Reset (clr=1 at an edge):
  - state=IDLE; MAR=0, MDR=0.
  - rsp_valid=0, rsp_err=0, ram_read=0, ram_write=0.
  - req_ready=1 from the next cycle.
  - clr overrides every other input.
- States: IDLE, RD_REQ, RD_CAP, WR, DONE. Strobes are Moore-decoded from the state:
  - ram_read=1 only in RD_REQ.
  - ram_write=1 only in WR.
  - The strobes are never high in the same cycle.
- IDLE:
  - req_ready=1.
  - On req_valid=1: MAR<=req_addr[ADDR-1:0]; on a store, MDR<=req_wdata.
  - Range check: if req_addr[BITS-1:ADDR] != 0, then rsp_err<=1 and go to DONE with no strobe. Otherwise go to RD_REQ (load) or WR (store).
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored and does not queue.
- RD_REQ: ram_read=1 for exactly one cycle. At the edge the RAM latches RAM[mar]. Next state is RD_CAP.
- RD_CAP: MDR<=ram_dataOut at the edge. Next state is DONE.
- WR: ram_write=1 for exactly one cycle. The RAM writes MDR at the edge. Next state is DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_rdata=MDR.
  - rsp_err is held from IDLE and cleared on exit.
  - Next state is IDLE.
- Latency, counted from the acceptance edge:
  - Load: rsp_valid is high in the 3rd cycle after acceptance.
  - Store: 2nd cycle.
  - Range error: 1st cycle.
  - Minimum repeat interval: 4 cycles for loads, 3 for stores.
- MDR holds its value between accesses. A store followed by a load returns the new word (RAW through the RAM).
- Reset mid-operation:
  - Any in-flight strobe drops in the cycle after the clr edge.
  - A partially completed load is discarded and no rsp_valid is produced.
  - A store whose WR edge coincided with clr=1 may still have been written by the RAM, since the RAM has no reset. The data is then undefined, but no response is issued.
- Widths: MAR is unsigned ADDR bits. No address increment or wrap; each address is supplied explicitly.

Decomposition:
- Shared package:
  - State enumeration localparams (IDLE=0, RD_REQ=1, RD_CAP=2, WR=3, DONE=4), 3-bit state width.
  - BITS/RAMSIZE defaults shared with the RAM.
- One sub-module is natural: mdr_reg, a BITS-wide register with sync clr, a load enable and a 2:1 source mux (req_wdata vs ram_dataOut). MAR stays inline.

Test Plan:
- Store then load: store 0x0000F7F7 to addr 85, then load addr 85 -> ram_write high exactly 1 cycle with ram_address=85; on the load, rsp_rdata=0x0000F7F7 in the 3rd cycle after acceptance.
- Latency/strobe check: load addr 4 (preloaded 0x08880055) -> ram_read high only in cycle 1 after acceptance; rsp_valid only in cycle 3; ram_read and ram_write never high together.
- Range error: load req_addr=0x200 -> rsp_err=1 with rsp_valid in cycle 1; ram_read and ram_write stay 0; mar=0x000.
- Busy: hold req_valid=1 continuously with alternating store/load to addrs 10 and 11 -> req_ready=0 outside IDLE; requests are accepted exactly every 3 or 4 cycles; no request is lost or duplicated.
- Reset mid-load: clr=1 during RD_CAP -> next cycle state=IDLE, mar=0, rsp_valid never pulses, req_ready=1.
- Boundary address: store 0xDEADBEEF to addr 511, then load -> 0xDEADBEEF, rsp_err=0.
